// File: rtl/path_node_port.sv
// Memory-mapped path-exchange peripheral: SP/EP registers, a FWFT FIFO of CPU-stored
// node points, and a done handshake with the downstream navigation sequencer.
module path_node_port #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NODE_W = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic                     Ext_MemWrite,
  input  logic [31:0]              Ext_DataAdr,
  input  logic [31:0]              Ext_WriteData,
  output logic                     mmio_hit,
  output logic [31:0]              mmio_rdata,
  input  logic                     node_rd_en,
  output logic [NODE_W-1:0]        node_rd_data,
  output logic                     node_valid,
  output logic [$clog2(DEPTH):0]   node_count,
  output logic                     overflow,
  output logic                     late_err,
  output logic                     path_done,
  input  logic                     done_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [31:0] ADR_SP     = 32'h0200_0001;
  localparam logic [31:0] ADR_EP     = 32'h0200_0002;
  localparam logic [31:0] ADR_NODE   = 32'h0200_0003;
  localparam logic [31:0] ADR_DONE   = 32'h0200_0004;
  localparam logic [31:0] ADR_STATUS = 32'h0200_0005;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state, stateNxt;

  logic [NODE_W-1:0] spReg, epReg, nodeLast;
  logic [NODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [CW-1:0]     count, countNxt;
  logic              ovfReg, lateReg;

  logic cpuWr, cpuNode, cpuDone, inDone, full;
  logic popEn, pushReq, pushEn, ovfSet, lateSet;
  logic unusedExtData;

  // Host bits above the node width carry no meaning for any register.
  assign unusedExtData = ^Ext_WriteData[31:NODE_W];

  // Host strobe pre-empts the CPU; done_clr masks every CPU NODE/DONE effect.
  assign cpuWr   = MemWrite & ~Ext_MemWrite;
  assign cpuNode = cpuWr & (DataAdr == ADR_NODE) & ~done_clr;
  assign cpuDone = cpuWr & (DataAdr == ADR_DONE) & (WriteData == 32'd1) & ~done_clr;
  assign inDone  = (state == S_DONE);
  assign full    = (count == CW'(DEPTH));

  assign popEn   = node_rd_en & (count != '0) & ~done_clr;
  assign pushReq = cpuNode & ~inDone;
  assign pushEn  = pushReq & (~full | popEn);
  assign ovfSet  = pushReq & full & ~popEn;
  assign lateSet = cpuNode & inDone;

  always_comb begin
    countNxt = count;
    if (pushEn && !popEn) begin
      countNxt = count + CW'(1);
    end else if (popEn && !pushEn) begin
      countNxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    if (done_clr) begin
      stateNxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpuDone) begin
            stateNxt = S_DONE;
          end else if (pushEn) begin
            stateNxt = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (cpuDone) begin
            stateNxt = S_DONE;
          end else if (countNxt == '0) begin
            stateNxt = S_IDLE;
          end
        end
        S_DONE: stateNxt = S_DONE;
        default: stateNxt = S_IDLE;
      endcase
    end
  end

  // Configuration registers; NODE-last ignores CPU stores while done is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spReg    <= '0;
      epReg    <= '0;
      nodeLast <= '0;
    end else if (Ext_MemWrite) begin
      if (Ext_DataAdr == ADR_SP)   spReg    <= Ext_WriteData[NODE_W-1:0];
      if (Ext_DataAdr == ADR_EP)   epReg    <= Ext_WriteData[NODE_W-1:0];
      if (Ext_DataAdr == ADR_NODE) nodeLast <= Ext_WriteData[NODE_W-1:0];
    end else if (MemWrite) begin
      if (DataAdr == ADR_SP) spReg <= WriteData[NODE_W-1:0];
      if (DataAdr == ADR_EP) epReg <= WriteData[NODE_W-1:0];
      if (pushReq)           nodeLast <= WriteData[NODE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      ovfReg  <= 1'b0;
      lateReg <= 1'b0;
    end else if (done_clr) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      ovfReg  <= 1'b0;
      lateReg <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + AW'(1);
      if (popEn)  rdPtr <= rdPtr + AW'(1);
      count   <= countNxt;
      ovfReg  <= ovfReg | ovfSet;
      lateReg <= lateReg | lateSet;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtr] <= WriteData[NODE_W-1:0];
    end
  end

  assign node_valid   = (count != '0);
  assign node_rd_data = node_valid ? mem[rdPtr] : '0;
  assign node_count   = count;
  assign overflow     = ovfReg;
  assign late_err     = lateReg;
  assign path_done    = inDone;

  always_comb begin
    mmio_hit   = 1'b0;
    mmio_rdata = '0;
    case (DataAdr)
      ADR_SP: begin
        mmio_hit   = 1'b1;
        mmio_rdata = 32'(spReg);
      end
      ADR_EP: begin
        mmio_hit   = 1'b1;
        mmio_rdata = 32'(epReg);
      end
      ADR_NODE: begin
        mmio_hit   = 1'b1;
        mmio_rdata = 32'(nodeLast);
      end
      ADR_DONE: begin
        mmio_hit   = 1'b1;
        mmio_rdata = 32'(inDone);
      end
      ADR_STATUS: begin
        mmio_hit       = 1'b1;
        mmio_rdata     = 32'(count);
        mmio_rdata[31] = ovfReg;
        mmio_rdata[30] = lateReg;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/path_node_port.md
# path_node_port

Memory-mapped path-exchange peripheral on the RISC-V core's data bus. Holds START_POINT and END_POINT, written by the host load port or the CPU. Captures every NODE_POINT the CPU stores into a first-word-fall-through FIFO, and raises a done flag when the CPU writes 1 to the DONE register. Downstream logic (motor/navigation sequencer) drains the FIFO instead of snooping bus writes.

## Interface
Parameters:
- DEPTH, 32, node FIFO entries (power of two, ≥2)
- NODE_W, 5, node-point width in bits

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- MemWrite  in  1  CPU store strobe
- DataAdr  in  32  CPU data address
- WriteData  in  32  CPU store data
- Ext_MemWrite  in  1  host load strobe (priority over CPU)
- Ext_DataAdr  in  32  host load address
- Ext_WriteData  in  32  host load data
- mmio_hit  out  1  DataAdr decodes to 0x02000001–0x02000005
- mmio_rdata  out  32  read data for DataAdr (zero when no hit)
- node_rd_en  in  1  pop FIFO head
- node_rd_data  out  NODE_W  FIFO head (valid only while node_valid)
- node_valid  out  1  FIFO non-empty
- node_count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: push attempted while full
- late_err  out  1  sticky: NODE write while in DONE
- path_done  out  1  DONE register bit
- done_clr  in  1  acknowledge: clear done, flush FIFO, clear sticky flags

## Operation
- Register map:
  - 0x02000001: SP (NODE_W bits, RW).
  - 0x02000002: EP (RW).
  - 0x02000003: NODE (write pushes WriteData[NODE_W-1:0]; read returns last node written).
  - 0x02000004: DONE (write with data==1 sets path_done; other data ignored; read returns {31'b0, path_done}).
  - 0x02000005: STATUS (RO: bit31 overflow, bit30 late_err, count in low bits).
- Reads are zero-extended to 32 bits. Writes to STATUS are ignored.
- Write arbitration:
  - If Ext_MemWrite=1, the host write is applied and any CPU write that cycle is dropped.
  - Host writes reach SP, EP and NODE-last only. They never push the FIFO and never set DONE.
- FSM, state encoding free:
  - IDLE: FIFO empty and done=0.
  - IDLE→COLLECT on a CPU NODE push.
  - COLLECT→IDLE when pops empty the FIFO and done=0.
  - IDLE or COLLECT→DONE on a CPU DONE=1 write.
  - DONE: CPU NODE writes are not pushed, NODE-last is not updated, and late_err is set. Pops continue.
  - done_clr (any state)→IDLE: FIFO flushed, count=0, overflow=late_err=path_done=0. SP, EP and NODE-last are retained.
- FIFO:
  - Pointers wrap modulo DEPTH. count is DEPTH when full.
  - Push while full: data dropped, overflow set, pointers unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. This includes the full case, where no overflow is raised.
  - Pop while empty: ignored.
- CPU write of NODE and done_clr in the same cycle: done_clr wins and no push occurs.

## Timing
- Reset (async assert, sync-safe deassert):
  - SP, EP, NODE-last, pointers, count, path_done, overflow and late_err are all 0. FSM is in IDLE.
  - Outputs are 0 immediately on reset_n low. Reset mid-collection discards all entries.
- mmio_hit and mmio_rdata are combinational from DataAdr and current register state. A store is visible on read the cycle after its clock edge.
- Push latency: node_valid and node_count update on the edge after the store. node_rd_data is the head combinationally (FWFT).
- Pop: node_rd_en sampled at the rising edge. The next entry appears after that edge.
- path_done rises one edge after the DONE store and stays high until done_clr or reset.

## Test plan
- Reset then host writes SP=0, EP=7, NODE=0 with CPU idle → reads return 0, 7, 0; node_count=0; FSM IDLE; path_done=0.
- CPU stores nodes 0, 3, 5, 7 to 0x02000003, then 1 to 0x02000004 → node_count=4; popping yields 0, 3, 5, 7 in order; path_done=1 one edge after the DONE store.
- Host writes EP=9 and CPU writes NODE=4 in the same cycle → EP=9, no push, node_count unchanged.
- Push DEPTH+1 nodes without popping → node_count=DEPTH, overflow=1, head equals the first node. Next cycle, push and pop simultaneously → count stays DEPTH, no new overflow.
- After DONE, CPU stores NODE=2 → late_err=1, count unchanged. Then pulse done_clr → path_done=0, count=0, flags cleared, SP/EP retained.
- Deassert reset_n mid-collection with 3 entries held → all outputs 0 asynchronously. After release, node_valid=0 and STATUS=0.
